// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus bundle: PC write port, imem port, decode port
// fetch_misaligned_o is present only when IFETCH_MISALIGN_CHECK_EN is defined.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_addr_i;
  logic                  pc_we_o;
  logic [ADDR_WIDTH-1:0] pc_next_o;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_addr_i;
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_ready_i;
  logic                  imem_rvalid_i;
  logic [31:0]           imem_rdata_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [31:0]           instr_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic                  fetch_misaligned_o;
`endif

  modport master (
    input  pc_addr_i, redirect_i, redirect_addr_i, imem_ready_i, imem_rvalid_i,
           imem_rdata_i, instr_ready_i,
    output pc_we_o, pc_next_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o,
           instr_addr_o
`ifdef IFETCH_MISALIGN_CHECK_EN
    , output fetch_misaligned_o
`endif
  );

  modport slave (
    output pc_addr_i, redirect_i, redirect_addr_i, imem_ready_i, imem_rvalid_i,
           imem_rdata_i, instr_ready_i,
    input  pc_we_o, pc_next_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o,
           instr_addr_o
`ifdef IFETCH_MISALIGN_CHECK_EN
    , input fetch_misaligned_o
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with credit-limited in-order buffer
// Optional misaligned-redirect flag enabled by IFETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic                clk_i,
  input logic                reset_ni,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] L_DEPTH    = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW:0] L_DEPTH_M1 = (CW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [CW-1:0]         r_wptr;
  logic [CW-1:0]         r_rptr;
  logic [CW:0]           r_count;
  logic [CW:0]           w_count_eff;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  w_redirect;
  logic                  w_grant;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_block;
  logic                  w_pc_we;
  logic [ADDR_WIDTH-1:0] w_pc_next;

  // Gating with reset keeps the PC write port quiet while reset is held.
  assign w_redirect  = bus.redirect_i && reset_ni;
  assign w_grant     = (r_state == REQ) && bus.imem_ready_i;
  assign w_pop       = (r_count != '0) && bus.instr_ready_i && !w_redirect;
  assign w_count_eff = r_count - {{CW{1'b0}}, w_pop};

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_misaligned;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_misaligned <= 1'b0;
    end else if (w_redirect) begin
      r_misaligned <= |bus.redirect_addr_i[1:0];
    end
  end
  assign w_block                = r_misaligned;
  assign bus.fetch_misaligned_o = r_misaligned;
`else
  assign w_block = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Credit counts the response being requested, so a push always finds room.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_next   = '0;
    case (r_state)
      IDLE: begin
        if (!w_redirect && !w_block && (w_count_eff < L_DEPTH)) w_state_nxt = REQ;
      end
      REQ: begin
        if (w_redirect) w_state_nxt = bus.imem_ready_i ? DROP : IDLE;
        else if (bus.imem_ready_i) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid_i) begin
          w_push      = !w_redirect;
          w_state_nxt = (!w_redirect && !w_block && (w_count_eff < L_DEPTH_M1)) ? REQ : IDLE;
        end else if (w_redirect) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.imem_rvalid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_redirect) begin
      w_pc_we   = 1'b1;
      w_pc_next = bus.redirect_addr_i;
    end else if (w_grant) begin
      w_pc_we   = 1'b1;
      w_pc_next = bus.pc_addr_i + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_req_addr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_addr[i] <= '0;
      end
    end else begin
      if (w_grant) r_req_addr <= bus.pc_addr_i;
      if (w_redirect) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) begin
          r_fifo_data[r_wptr] <= bus.imem_rdata_i;
          r_fifo_addr[r_wptr] <= r_req_addr;
          r_wptr              <= r_wptr + CW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + CW'(1);
        r_count <= r_count + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
      end
    end
  end

  assign bus.pc_we_o       = w_pc_we;
  assign bus.pc_next_o     = w_pc_next;
  assign bus.imem_req_o    = (r_state == REQ);
  assign bus.imem_addr_o   = bus.pc_addr_i;
  assign bus.instr_valid_o = (r_count != '0);
  assign bus.instr_o       = r_fifo_data[r_rptr];
  assign bus.instr_addr_o  = r_fifo_addr[r_rptr];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a transaction-level model
module tb_instr_fetch_unit;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();
  instr_fetch_unit #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Model: buffered {data, addr} entries, PC register, one outstanding fetch.
  logic [63:0] q [$];
  logic [31:0] pc = '0;
  logic [31:0] cap_addr = '0;
  bit          outstanding = 0;
  bit          resp_live = 0;
  bit          exp_req = 0;
  int          delay_cnt = 0;
  int          grants = 0;
  logic [31:0] first_grant_next = '0;
  logic [31:0] last_we_next = '0;
  logic [31:0] first_req_addr = '0;
  bit          watch_req = 0;

  int          p_redir = 0, p_mem = 100, p_dec = 100, dly_min = 1, dly_max = 1;
  bit          f_redir = 0, f_pop = 0, f_rvalid = 0;
  logic [31:0] f_redir_addr = '0;

  task automatic drive();
    bus.pc_addr_i     = pc;
    bus.imem_ready_i  = ($urandom_range(99) < p_mem);
    bus.instr_ready_i = f_pop || ($urandom_range(99) < p_dec);
    f_pop = 0;
    if (f_redir) begin
      bus.redirect_i      = 1'b1;
      bus.redirect_addr_i = f_redir_addr;
      f_redir = 0;
    end else begin
      bus.redirect_i      = ($urandom_range(99) < p_redir);
      bus.redirect_addr_i = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(3) << 2)
                                                      : ($urandom_range(16383) << 2);
    end
    if (outstanding) begin
      delay_cnt--;
      bus.imem_rvalid_i = (delay_cnt <= 0);
    end else begin
      bus.imem_rvalid_i = f_rvalid;
    end
    f_rvalid = 0;
    bus.imem_rdata_i = bus.imem_rvalid_i ? mem_word(cap_addr) : $urandom;
  endtask

  task automatic sample();
    bit          redir, rv, grant, pop, pushed, nreq, exp_we;
    int          sz;
    logic [31:0] exp_next;
    redir  = bus.redirect_i;
    rv     = bus.imem_rvalid_i;
    sz     = q.size();
    pop    = (sz != 0) && bus.instr_ready_i;
    grant  = exp_req && bus.imem_ready_i;
    exp_we = redir || grant;
    exp_next = redir ? bus.redirect_addr_i : pc + 32'd4;
    check_val("instr_valid", bus.instr_valid_o, (sz != 0));
    if (sz != 0) begin
      check_val("instr_o", bus.instr_o, q[0][63:32]);
      check_val("instr_addr", bus.instr_addr_o, q[0][31:0]);
    end
    check_val("imem_req", bus.imem_req_o, exp_req);
    check_val("imem_addr", bus.imem_addr_o, pc);
    check_val("pc_we", bus.pc_we_o, exp_we);
    if (exp_we) begin
      check_val("pc_next", bus.pc_next_o, exp_next);
      last_we_next = bus.pc_next_o;
    end
    if (watch_req && bus.imem_req_o) begin
      first_req_addr = bus.imem_addr_o;
      watch_req = 0;
    end
    if (grant) begin
      if (grants == 0) first_grant_next = bus.pc_next_o;
      grants++;
    end
    pushed = 0;
    if (redir) begin
      q.delete();
      resp_live = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (rv && outstanding && resp_live) begin
        q.push_back({mem_word(cap_addr), cap_addr});
        pushed = 1;
      end
    end
    if (redir) nreq = 0;
    else if (exp_req) nreq = !bus.imem_ready_i;
    else if (!outstanding) nreq = (sz - int'(pop)) < DEPTH;
    else nreq = pushed && ((sz - int'(pop) + 1) < DEPTH);
    if (rv) outstanding = 0;
    if (grant) begin
      outstanding = 1;
      resp_live   = !redir;
      cap_addr    = pc;
      delay_cnt   = $urandom_range(dly_max, dly_min);
    end
    if (exp_we) pc = exp_next;
    exp_req = nreq;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    sample();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_pc_we"}, bus.pc_we_o, 1'b0);
    check_val({tag, "_imem_req"}, bus.imem_req_o, 1'b0);
    check_val({tag, "_instr_valid"}, bus.instr_valid_o, 1'b0);
    check_val({tag, "_pc_next"}, bus.pc_next_o, 32'h0);
    check_val({tag, "_instr_o"}, bus.instr_o, 32'h0);
    check_val({tag, "_instr_addr"}, bus.instr_addr_o, 32'h0);
  endtask

  initial begin
    bit ok;
    bus.pc_addr_i = '0; bus.redirect_i = 1'b0; bus.redirect_addr_i = '0;
    bus.imem_ready_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    bus.instr_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");

    // Sequential fetch from 0: grants on cycles 1, 3, 5 of the run.
    release_reset();
    repeat (5) cycle();
    check_val("seq_grants", grants, 3);
    check_val("seq_last_next", last_we_next, 32'hC);

    // Credit: decode stalled, exactly DEPTH fetches complete.
    p_dec = 0; f_redir = 1; f_redir_addr = 32'h40;
    cycle();
    grants = 0;
    repeat (20) cycle();
    check_val("credit_grants", grants, 2);
    check_val("credit_req_idle", bus.imem_req_o, 1'b0);
    f_pop = 1;
    repeat (20) cycle();
    check_val("credit_one_more", grants, 3);

    // Redirect while waiting for data.
    p_dec = 100; dly_min = 3; dly_max = 3; ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (outstanding && delay_cnt >= 2) begin ok = 1; break; end
    end
    check_val("wait_setup", ok, 1'b1);
    f_redir = 1; f_redir_addr = 32'h100; watch_req = 1;
    cycle();
    check_val("wait_redir_next", last_we_next, 32'h100);
    dly_min = 1; dly_max = 1;
    repeat (10) cycle();
    check_val("wait_redir_req_addr", first_req_addr, 32'h100);

    // Redirect on the grant cycle.
    p_mem = 0; ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (exp_req && !outstanding) begin ok = 1; break; end
    end
    check_val("grant_setup", ok, 1'b1);
    p_mem = 100; f_redir = 1; f_redir_addr = 32'h200;
    cycle();
    check_val("grant_redir_next", last_we_next, 32'h200);
    repeat (8) cycle();

    // PC wrap at the top of the address space.
    f_redir = 1; f_redir_addr = 32'hFFFF_FFFC;
    cycle();
    grants = 0;
    repeat (6) cycle();
    check_val("wrap_next", first_grant_next, 32'h0);

    // Random traffic.
    p_redir = 5; p_mem = 60; p_dec = 60; dly_min = 1; dly_max = 4;
    repeat (3000) cycle();

    // Asynchronous reset with one buffered entry and a fetch in flight.
    p_redir = 0; p_mem = 100; p_dec = 0; dly_min = 3; dly_max = 3;
    f_redir = 1; f_redir_addr = 32'h80;
    cycle();
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (q.size() == 1 && outstanding && delay_cnt >= 2) begin ok = 1; break; end
    end
    check_val("rst_setup", ok, 1'b1);
    @(posedge clk);
    #1 drive();
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    q.delete(); outstanding = 0; resp_live = 0; exp_req = 0;
    repeat (2) @(posedge clk);
    p_dec = 100; dly_min = 1; dly_max = 1; f_rvalid = 1; grants = 0;
    release_reset();
    repeat (10) cycle();
    check_val("restart_grants", (grants > 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end; consumes the program counter value and advances it.
- Reads the current PC, issues word requests to instruction memory, and buffers returned instructions in a small in-order FIFO.
- Presents buffered instructions to decode over a valid/ready handshake.
- Drives the PC write port for sequential advance (+4) and for branch/jump redirects; redirect flushes buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_ni  input  1  asynchronous active-low reset.
- pc_addr_i  input  ADDR_WIDTH  current PC value.
- pc_we_o  output  1  PC write enable, one-cycle pulse.
- pc_next_o  output  ADDR_WIDTH  value written to PC when pc_we_o=1.
- redirect_i  input  1  branch/jump taken; flush and refetch.
- redirect_addr_i  input  ADDR_WIDTH  redirect target.
- imem_req_o  output  1  memory request valid.
- imem_addr_o  output  ADDR_WIDTH  request address; always equals pc_addr_i.
- imem_ready_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  instruction word.
- instr_valid_o  output  1  FIFO head valid.
- instr_ready_i  input  1  decode consumes the head.
- instr_o  output  32  head instruction.
- instr_addr_o  output  ADDR_WIDTH  address of the head instruction.

Behaviour:
- Reset (reset_ni=0, asynchronous): state IDLE; FIFO count 0; instr_valid_o, imem_req_o and pc_we_o all 0; pc_next_o, instr_o and instr_addr_o all 0.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req_o=1, waiting for imem_ready_i.
  - WAIT: request granted, waiting for imem_rvalid_i.
  - DROP: waiting for a response that must be discarded.
- Maximum one outstanding request.
- Credit rule: issue only when FIFO count plus the one response being issued stays at or below FIFO_DEPTH. Count includes a same-cycle pop.
- IDLE → REQ when credit is available and redirect_i=0.
- REQ → WAIT on imem_ready_i. Grant cycle: pc_we_o=1 and pc_next_o=pc_addr_i+4, modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0x00000000.
- Capture the granted address for instr_addr_o.
- imem_req_o and imem_addr_o must hold stable in REQ until granted.
- WAIT → IDLE on imem_rvalid_i: push {imem_rdata_i, captured address}.
- Back-to-back: if credit remains, the WAIT response cycle may go directly to REQ, giving one request per 2 cycles minimum.
- FIFO:
  - instr_valid_o = (count != 0); head is registered output.
  - Pop when instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full FIFO never receives a push, guaranteed by the credit rule.
- Redirect (redirect_i=1), highest priority:
  - pc_we_o=1, pc_next_o=redirect_addr_i.
  - FIFO cleared the same edge; instr_valid_o=0 the next cycle.
  - A same-cycle pop has no effect.
  - From REQ: request withdrawn unless imem_ready_i=1 that cycle. If granted that cycle, go to DROP; otherwise go to IDLE. No +4 write occurs.
  - From WAIT: go to DROP, unless imem_rvalid_i=1 that cycle, in which case go to IDLE with the data discarded.
  - DROP → IDLE on imem_rvalid_i; data not pushed.
  - Redirect in DROP: PC is written again; stay in DROP.
- No request is issued in the redirect cycle. The first fetch from the new PC is requested the next cycle at the earliest.
- pc_we_o asserts only on a grant or a redirect. It never asserts twice in one cycle; redirect wins.

Optional Feature:
- Macro IFETCH_MISALIGN_CHECK_EN.
- When defined, adds output fetch_misaligned_o (1 bit, reset 0).
  - A redirect with redirect_addr_i[1:0] != 0 still writes the PC but sets fetch_misaligned_o=1.
  - While the flag is set, the block issues no requests.
  - The flag clears on the next redirect with an aligned target.
- When undefined: the port is absent, no check is made, and fetch proceeds from the unmodified address.

Test Plan:
- Reset release with pc_addr_i=0x0, imem_ready_i=1, rvalid one cycle after grant, instr_ready_i=1 → requests to 0x0, 0x4, 0x8. pc_we_o pulses with pc_next_o 0x4, 0x8, 0xC. instr_o/instr_addr_o appear in order.
- instr_ready_i=0 and FIFO_DEPTH=2 → exactly 2 requests complete, no third request, imem_req_o stays 0. A single pop then allows exactly one more request.
- Redirect to 0x100 while in WAIT → response discarded (DROP). FIFO emptied. pc_next_o=0x100. Next request address is 0x100.
- Redirect in the same cycle as a REQ grant → pc_next_o=redirect target, not +4. The following rvalid data is not pushed.
- pc_addr_i=0xFFFFFFFC granted → pc_next_o=0x00000000.
- Assert reset_ni=0 mid-WAIT with FIFO holding 1 entry → all outputs 0 asynchronously. After release, a stray rvalid is ignored (state IDLE) and fetch restarts cleanly.
